// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the fetch/data memory arbiter.
package mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_BUSY = 2'd1;
  localparam logic [1:0] STATE_RESP = 2'd2;

  // Grant id doubles as the bit index of each port in eligibility/grant vectors.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: one-hot grant from eligibility, favouring the
// port that did not complete last.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] elig,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] gnt
);
  logic last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   last_grant <= GRANT_D;
    else if (upd) last_grant <= upd_id;
  end

  always_comb begin
    gnt = '0;
    if (&elig) gnt[~last_grant] = 1'b1;
    else       gnt = elig;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the IF read port and MEM data port onto one req/ack memory bus,
// returning data with a one-cycle ack to the granted port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W = mem_arbiter_pkg::DATA_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [1:0] state;
  logic       gnt_q;
  logic       just_acked;
  logic [1:0] elig;
  logic [1:0] gnt;

  // A port that was acked last cycle may still show req if it registers the drop.
  always_comb begin
    elig = '0;
    if (state == STATE_IDLE) begin
      elig[GRANT_I] = i_req && !(just_acked && gnt_q == GRANT_I);
      elig[GRANT_D] = d_req && !(just_acked && gnt_q == GRANT_D);
    end
  end

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .elig   (elig),
    .upd    (state == STATE_BUSY && mem_ack),
    .upd_id (gnt_q),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= STATE_IDLE;
      gnt_q      <= GRANT_D;
      just_acked <= 1'b0;
      i_ack      <= 1'b0;
      i_data     <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      just_acked <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (gnt[GRANT_I]) begin
            gnt_q     <= GRANT_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            state     <= STATE_BUSY;
          end else if (gnt[GRANT_D]) begin
            gnt_q     <= GRANT_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            state     <= STATE_BUSY;
          end
        end
        STATE_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (gnt_q == GRANT_I) begin
              i_data <= mem_rdata;
              i_ack  <= 1'b1;
            end else begin
              d_rdata <= mem_we ? '0 : mem_rdata;
              d_ack   <= 1'b1;
            end
            state <= STATE_RESP;
          end
        end
        STATE_RESP: begin
          just_acked <= 1'b1;
          state      <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: queued requesters and a stalling memory,
// checked every cycle against a cycle-count based reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_data;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    bit            linger;
  } txn_t;
  typedef struct {
    int            dly;
    logic [DW-1:0] data;
  } rsp_t;

  txn_t iq[$], dq[$];
  rsp_t mq[$];
  int   ack_log[$], ack_cyc[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int n_push = 0, n_ack = 0;
  bit stray = 0;

  // requester / memory driver state
  bit            act[2], lgr[2];
  int            lng[2], start[2], lat[2];
  bit            m_pend;
  int            m_cnt;
  logic [DW-1:0] m_data;

  // reference model: who owns the bus, and the cycle numbers that gate grants
  int            m_owner, m_last, m_next, m_blk;
  int            e_ack[2];
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_idata, e_drdata;
  logic [BW-1:0] e_be;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mreset();
    m_owner = -1; m_last = 1; m_next = 0; m_blk = -1;
    e_ack[0] = -1; e_ack[1] = -1;
    e_idata = '0; e_drdata = '0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
  endtask

  task automatic model();
    bit ei, ed;
    int g;
    if (m_owner >= 0) begin
      if (mem_ack) begin
        e_ack[m_owner] = cyc;
        if (m_owner == 0) e_idata = mem_rdata;
        else              e_drdata = e_we ? '0 : mem_rdata;
        m_last = m_owner; m_blk = m_owner; m_next = cyc + 2; m_owner = -1;
      end
    end else if (cyc >= m_next) begin
      ei = i_req && !(m_blk == 0 && cyc == m_next);
      ed = d_req && !(m_blk == 1 && cyc == m_next);
      g = (ei && ed) ? 1 - m_last : ei ? 0 : ed ? 1 : -1;
      if (g == 0) begin
        e_we = 1'b0; e_addr = i_addr; e_be = '1; e_wdata = '0;
      end else if (g == 1) begin
        e_we = d_we; e_addr = d_addr; e_be = d_be; e_wdata = d_wdata;
      end
      m_owner = g;
    end
  endtask

  task automatic drive_mem();
    rsp_t r;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!m_pend) begin
        if (mq.size() > 0) r = mq.pop_front();
        else begin
          r.dly  = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
          r.data = $urandom;
        end
        m_pend = 1; m_cnt = r.dly; m_data = r.data;
      end
      if (m_cnt == 0) begin
        mem_ack = 1'b1; mem_rdata = m_data; m_pend = 0;
      end else m_cnt--;
    end else if (stray && $urandom_range(0, 5) == 0) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
    end
  endtask

  task automatic drive_port(input int p);
    logic ack;
    bit   have;
    txn_t t;
    ack = (p == 0) ? i_ack : d_ack;
    if (act[p] && ack) begin
      act[p] = 0; lat[p] = cyc - start[p]; lng[p] = lgr[p] ? 2 : 0;
      n_ack++; ack_log.push_back(p); ack_cyc.push_back(cyc);
    end
    if (!act[p]) begin
      have = (p == 0) ? (iq.size() > 0) : (dq.size() > 0);
      if (lng[p] > 0) lng[p]--;
      else if (have) begin
        if (p == 0) t = iq.pop_front();
        else        t = dq.pop_front();
        act[p] = 1; start[p] = cyc; lgr[p] = t.linger;
        if (p == 0) begin
          i_req = 1'b1; i_addr = t.addr;
        end else begin
          d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_be = t.be;
        end
      end else if (p == 0) i_req = 1'b0;
      else                 d_req = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) mreset();
    else        model();
    @(negedge clk);
    chk("mem_req", mem_req, m_owner >= 0);
    if (m_owner >= 0) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_be", mem_be, e_be);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("i_ack", i_ack, e_ack[0] == cyc);
    chk("d_ack", d_ack, e_ack[1] == cyc);
    chk("i_data", i_data, e_idata);
    chk("d_rdata", d_rdata, e_drdata);
    if (!reset) begin
      act[0] = 0; act[1] = 0; lng[0] = 0; lng[1] = 0; m_pend = 0;
      i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    end else begin
      drive_mem();
      drive_port(0);
      drive_port(1);
    end
  endtask

  task automatic run_idle(input int budget);
    int k = 0;
    while (k < budget && !(iq.size() == 0 && dq.size() == 0 && !act[0] && !act[1] &&
                           lng[0] == 0 && lng[1] == 0 && m_owner < 0)) begin
      step();
      k++;
    end
    chk("idle_timeout", k < budget, 1);
    step();
    step();
  endtask

  initial begin
    txn_t t;
    int   k;
    mreset();
    step();
    step();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_we", mem_we, 0);
    reset = 1'b1;

    // single instruction read, zero-wait memory
    iq.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 1'b0});
    mq.push_back('{0, 32'hDEADBEEF});
    run_idle(50);
    chk("i_latency", lat[0], 2);
    chk("i_data_hold", i_data, 32'hDEADBEEF);

    // data read then data write: write must zero d_rdata
    dq.push_back('{1'b0, 32'h44, 32'h0, 4'hF, 1'b0});
    mq.push_back('{1, 32'hA5A5A5A5});
    run_idle(50);
    chk("d_rd_data", d_rdata, 32'hA5A5A5A5);
    dq.push_back('{1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0});
    mq.push_back('{0, 32'hCAFEF00D});
    run_idle(50);
    chk("d_wr_rdata", d_rdata, 0);

    // both ports held busy: grants must alternate
    ack_log.delete(); ack_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      iq.push_back('{1'b0, 32'h100 + 4 * i, 32'h0, 4'h0, 1'b0});
      dq.push_back('{1'b0, 32'h200 + 4 * i, 32'h0, 4'hF, 1'b0});
    end
    run_idle(200);
    chk("alt_count", ack_log.size(), 8);
    chk("alt_first_i", ack_log.size() > 0 && ack_log[0] == 0, 1);
    for (int i = 1; i < ack_log.size(); i++) chk("alt_order", ack_log[i] != ack_log[i-1], 1);

    // requester holds i_req one cycle after its ack
    ack_log.delete(); ack_cyc.delete();
    iq.push_back('{1'b0, 32'h300, 32'h0, 4'h0, 1'b1});
    iq.push_back('{1'b0, 32'h304, 32'h0, 4'h0, 1'b0});
    mq.push_back('{0, 32'h11111111});
    mq.push_back('{0, 32'h22222222});
    run_idle(60);
    chk("linger_acks", ack_cyc.size(), 2);
    if (ack_cyc.size() == 2) chk("linger_gap", ack_cyc[1] - ack_cyc[0], 4);

    // asynchronous reset in the middle of a stalled transaction
    iq.push_back('{1'b0, 32'h500, 32'h0, 4'h0, 1'b0});
    mq.push_back('{20, 32'h33333333});
    k = 0;
    while (!mem_req && k < 10) begin step(); k++; end
    chk("busy_reached", mem_req, 1);
    step(); step();
    #1 reset = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_i_ack", i_ack, 0);
    chk("arst_d_ack", d_ack, 0);
    chk("arst_i_data", i_data, 0);
    iq.delete(); dq.delete(); mq.delete();
    step();
    mem_ack = 1'b1; mem_rdata = 32'h44444444;
    step();
    step();
    reset = 1'b1;
    iq.push_back('{1'b0, 32'h600, 32'h0, 4'h0, 1'b0});
    mq.push_back('{1, 32'h55555555});
    run_idle(50);
    chk("post_rst_data", i_data, 32'h55555555);

    // 20-cycle memory stall on a write; fields checked stable every cycle
    ack_log.delete(); ack_cyc.delete();
    dq.push_back('{1'b1, 32'h700, 32'h0BADC0DE, 4'hC, 1'b0});
    mq.push_back('{20, 32'h66666666});
    run_idle(60);
    chk("stall_one_ack", ack_log.size(), 1);

    // random traffic with stray memory acks
    stray = 1;
    n_push = 0; n_ack = 0;
    for (int c = 0; c < 1500; c++) begin
      if (iq.size() < 2 && $urandom_range(0, 3) == 0) begin
        t.we = 1'b0; t.addr = $urandom; t.wdata = '0; t.be = '0;
        t.linger = ($urandom_range(0, 3) == 0);
        iq.push_back(t); n_push++;
      end
      if (dq.size() < 2 && $urandom_range(0, 3) == 0) begin
        t.we = $urandom_range(0, 1) == 1; t.addr = $urandom; t.wdata = $urandom;
        t.be = 4'($urandom_range(1, 15)); t.linger = ($urandom_range(0, 3) == 0);
        dq.push_back(t); n_push++;
      end
      step();
    end
    stray = 0;
    run_idle(300);
    chk("rand_ack_count", n_ack, n_push);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
